fb_wb_stage: RTL and testbench
==============================

FB_WB_STAGE -- requirements
Module: fb_wb_stage

Interface
REQ-001 The module SHALL have the port clk, an input of 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The module SHALL have the port reset, an input of 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have the port in_valid, an input of 1 bit: the MEM stage presents a retiring instruction.
REQ-004 The module SHALL have the port in_ready, an output of 1 bit: the stage can accept an instruction this cycle.
REQ-005 The module SHALL have the port in_rd, an input of 5 bits: the destination register.
REQ-006 The module SHALL have the port in_rd_we, an input of 1 bit: the instruction writes rd.
REQ-007 The module SHALL have the port in_result, an input of `FB_32BITS: the ALU or CSR result for non-load instructions.
REQ-008 The module SHALL have the port in_is_load, an input of 1 bit: the instruction is a load whose data arrives on dmem.
REQ-009 The module SHALL have the port in_ld_funct3, an input of 3 bits: the load type (LB=0, LH=1, LW=2, LBU=4, LHU=5).
REQ-010 The module SHALL have the port in_addr_lo, an input of 2 bits: the load byte address bits [1:0].
REQ-011 The module SHALL have the port dmem_rvalid, an input of 1 bit: the load data is valid this cycle.
REQ-012 The module SHALL have the port dmem_rdata, an input of `FB_32BITS: the word-aligned load data.
REQ-013 The module SHALL have the port rf_we, an output of 1 bit: the register-file write enable, high for one cycle per write.
REQ-014 The module SHALL have the port rf_waddr, an output of 5 bits: the register-file write address.
REQ-015 The module SHALL have the port rf_wdata, an output of `FB_32BITS: the register-file write data.
REQ-016 The module SHALL have the port ld_err, an output of 1 bit: a one-cycle pulse on a misaligned or illegal load.
REQ-017 The module SHALL have the port instret, an output of 64 bits: the count of retired instructions.

Function
REQ-018 The stage SHALL have two states: IDLE and WAIT_LD. in_ready SHALL be 1 exactly when the state is IDLE.
REQ-019 An accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-020 For an accept of a non-load in IDLE, the write SHALL appear on the next cycle: rf_we = in_rd_we && in_rd != 0, rf_waddr = in_rd, rf_wdata = in_result. The state SHALL stay IDLE.
REQ-021 Back-to-back non-load accepts SHALL produce one write per cycle, with no bubble.
REQ-022 For an accept of a load in IDLE, the stage SHALL capture rd, rd_we, funct3 and addr_lo, and SHALL go to WAIT_LD. No write SHALL occur that cycle.
REQ-023 In WAIT_LD, dmem_rvalid=1 SHALL cause one write on the next cycle, carrying the aligned and extended data, and the state SHALL return to IDLE. A new accept SHALL be possible from that next cycle.
REQ-024 In WAIT_LD with dmem_rvalid=0, the stage SHALL hold with no timeout.
REQ-025 dmem_rvalid asserted in IDLE SHALL be ignored and SHALL have no effect.
REQ-026 Load alignment for LB/LBU SHALL select byte addr_lo, with sign/zero extension respectively.
REQ-027 Load alignment for LH/LHU SHALL select halfword addr_lo[1], with sign/zero extension respectively.
REQ-028 Load alignment for LW SHALL pass the word through unchanged.
REQ-029 A load SHALL be an error when it is LH/LHU with addr_lo[0]=1, LW with addr_lo≠0, or has funct3 ∈ {3,6,7}.
REQ-030 For an error load, the stage SHALL still wait for dmem_rvalid, then SHALL suppress rf_we and pulse ld_err in the cycle the write would have occurred.
REQ-031 rf_waddr and rf_wdata SHALL hold their last values whenever rf_we=0.
REQ-032 instret SHALL increment by 1 for each completed instruction, in the cycle its write slot occurs, whether or not rf_we or ld_err is set.
REQ-033 instret SHALL wrap from 2^64-1 to 0.

Reset
REQ-034 When reset=1, the state SHALL asynchronously go to IDLE, and rf_we SHALL be 0, rf_waddr 0, rf_wdata 0, ld_err 0 and instret 0.
REQ-035 Reset while in WAIT_LD SHALL abandon the pending load, and a later dmem_rvalid SHALL be ignored.
REQ-036 in_ready SHALL be 1 as soon as reset deasserts.

Structure
REQ-037 `FB_32BITS and the load funct3 codes SHALL be defined in fb_defines.v.
REQ-038 The byte/halfword select, the sign/zero extension and the error detection SHALL form one combinational sub-module, fb_load_align (inputs: funct3, addr_lo, rdata; outputs: data, err).

Verification
REQ-039 Non-load back-to-back: accepting rd=5 with result 0x11, then rd=6 with result 0x22, on consecutive cycles SHALL give rf_we=1 on two consecutive cycles, with (5, 0x11) then (6, 0x22), and instret=2.
REQ-040 x0 suppression: a non-load with rd=0, rd_we=1, result 0xFFFF_FFFF SHALL give rf_we=0, and instret SHALL still increment.
REQ-041 LB sign-extension: LB with addr_lo=3, dmem_rdata=0x80_12_34_56, and rvalid 3 cycles after accept SHALL give in_ready=0 for 3 cycles, then rf_wdata=0xFFFF_FF80 one cycle after rvalid.
REQ-042 LHU zero-extension: LHU with addr_lo=2 and rdata=0xBEEF_1234 SHALL give rf_wdata=0x0000_BEEF.
REQ-043 Misaligned LW: LW with addr_lo=1 SHALL give ld_err for one cycle, rf_we=0, and instret+1.
REQ-044 Reset mid-load: reset asserted in WAIT_LD, followed by dmem_rvalid=1 after reset deasserts, SHALL produce no write, and in_ready SHALL be 1.

Source files
------------

// File: rtl/fb_wb_stage_pkg.sv
// Types, state encodings and helpers shared by the write-back stage.
package fb_wb_stage_pkg;

    // Two-state stage controller, legacy-style encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_WAIT_LD = 1'b1;

    // Context of a load parked while its data is outstanding
    typedef struct packed {
        logic [4:0] rd;
        logic       rd_we;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } ld_ctx_t;

    // A register write only happens for a real destination (x0 is hardwired)
    function automatic logic rd_writes(input logic we, input logic [4:0] rd);
        return we && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/fb_defines.v
// Shared width and load-type macros for the FB core.
`ifndef FB_DEFINES_V
`define FB_DEFINES_V

`define FB_32BITS 31:0

// Load funct3 encodings
`define FB_F3_LB  3'd0
`define FB_F3_LH  3'd1
`define FB_F3_LW  3'd2
`define FB_F3_LBU 3'd4
`define FB_F3_LHU 3'd5

`endif

// File: rtl/fb_load_align.sv
// Combinational load data alignment, extension and legality check.
`include "fb_defines.v"

module fb_load_align (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [`FB_32BITS] rdata,
    output logic [`FB_32BITS] data,
    output logic              err
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
    assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Select lane, extend it, and flag misaligned or unknown load types
    always_comb begin
        data = 32'd0;
        err  = 1'b0;
        case (funct3)
            `FB_F3_LB: begin
                data = {{24{byte_s[7]}}, byte_s};
            end
            `FB_F3_LBU: begin
                data = {24'd0, byte_s};
            end
            `FB_F3_LH: begin
                data = {{16{half_s[15]}}, half_s};
                err  = addr_lo[0];
            end
            `FB_F3_LHU: begin
                data = {16'd0, half_s};
                err  = addr_lo[0];
            end
            `FB_F3_LW: begin
                data = rdata;
                err  = (addr_lo != 2'd0);
            end
            default: begin
                data = 32'd0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fb_wb_stage.sv
// Write-back stage: retires MEM results into the register file, parking
// loads until their data returns, and counts retired instructions.
`include "fb_defines.v"

module fb_wb_stage
    import fb_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [`FB_32BITS] in_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_ld_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              dmem_rvalid,
    input  logic [`FB_32BITS] dmem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [`FB_32BITS] rf_wdata,
    output logic              ld_err,
    output logic [63:0]       instret
);

    logic [0:0]        state_q,    state_d;
    ld_ctx_t           ctx_q,      ctx_d;
    logic              rf_we_q,    rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [`FB_32BITS] rf_wdata_q, rf_wdata_d;
    logic              ld_err_q,   ld_err_d;
    logic [63:0]       instret_q,  instret_d;

    logic [`FB_32BITS] align_data_s;
    logic              align_err_s;

    // Alignment works on the parked context so in_* may change during the wait
    fb_load_align u_align (
        .funct3  (ctx_q.funct3),
        .addr_lo (ctx_q.addr_lo),
        .rdata   (dmem_rdata),
        .data    (align_data_s),
        .err     (align_err_s)
    );

    assign in_ready = (state_q == ST_IDLE);

    // Next-state: accept in IDLE, complete parked load when its data arrives
    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        ld_err_d   = 1'b0;
        instret_d  = instret_q;
        if (state_q == ST_IDLE) begin
            if (in_valid) begin
                if (in_is_load) begin
                    ctx_d.rd      = in_rd;
                    ctx_d.rd_we   = in_rd_we;
                    ctx_d.funct3  = in_ld_funct3;
                    ctx_d.addr_lo = in_addr_lo;
                    state_d       = ST_WAIT_LD;
                end else begin
                    instret_d = instret_q + 64'd1;
                    if (rd_writes(in_rd_we, in_rd)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = in_rd;
                        rf_wdata_d = in_result;
                    end else begin
                        rf_we_d    = 1'b0;
                    end
                end
            end else begin
                // Stray dmem_rvalid while idle is deliberately ignored
                state_d = ST_IDLE;
            end
        end else begin
            if (dmem_rvalid) begin
                state_d   = ST_IDLE;
                instret_d = instret_q + 64'd1;
                if (align_err_s) begin
                    ld_err_d = 1'b1;
                end else if (rd_writes(ctx_q.rd_we, ctx_q.rd)) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ctx_q.rd;
                    rf_wdata_d = align_data_s;
                end else begin
                    rf_we_d    = 1'b0;
                end
            end else begin
                // Hold indefinitely until the memory answers
                state_d = ST_WAIT_LD;
            end
        end
    end

    // State and output registers; reset abandons any parked load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctx_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            ld_err_q   <= 1'b0;
            instret_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            ld_err_q   <= ld_err_d;
            instret_q  <= instret_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign ld_err   = ld_err_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_fb_wb_stage.sv
// Self-checking bench for fb_wb_stage: directed vector table, reset-mid-load
// sequence, then random traffic against a behavioural model.
module tb_fb_wb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ld_err;
    logic [63:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    fb_wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .in_result    (in_result),
        .in_is_load   (in_is_load),
        .in_ld_funct3 (in_ld_funct3),
        .in_addr_lo   (in_addr_lo),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .ld_err       (ld_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] result;
        logic        is_load;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_err;
        logic        e_ready;
        logic [63:0] e_ret;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [31:0] res,
                         input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                         input logic rv, input logic [31:0] rdat);
        in_valid     = v;
        in_rd        = rd;
        in_rd_we     = we;
        in_result    = res;
        in_is_load   = ld;
        in_ld_funct3 = f3;
        in_addr_lo   = lo;
        dmem_rvalid  = rv;
        dmem_rdata   = rdat;
    endtask

    // Reference load result from the architectural rules: {err, data}
    function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] v;
        int unsigned sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = 8 * int'(lo);
                v  = (w >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
                return {1'b0, v};
            end
            3'd1, 3'd5: begin
                sh = 16 * (int'(lo) / 2);
                v  = (w >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                return {lo[0], v};
            end
            3'd2: return {(lo != 2'd0), w};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Model state for random phase
    bit          m_wait;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic        x_we;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_err;
    logic [63:0] x_ret;

    initial begin
        // valid rd we result load f3 lo rvalid rdata | we waddr wdata err ready ret
        vecs[0]  = '{1'b1, 5'd5, 1'b1, 32'h11, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0,          1'b1, 5'd5, 32'h11,        1'b0, 1'b1, 64'd1};
        vecs[1]  = '{1'b1, 5'd6, 1'b1, 32'h22, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0,          1'b1, 5'd6, 32'h22,        1'b0, 1'b1, 64'd2};
        vecs[2]  = '{1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0,   1'b0, 5'd6, 32'h22,        1'b0, 1'b1, 64'd3};
        vecs[3]  = '{1'b1, 5'd7, 1'b1, 32'd0,  1'b1, 3'd0, 2'd3, 1'b0, 32'd0,          1'b0, 5'd6, 32'h22,        1'b0, 1'b0, 64'd3};
        vecs[4]  = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b0, 32'd0,          1'b0, 5'd6, 32'h22,        1'b0, 1'b0, 64'd3};
        vecs[5]  = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b0, 32'd0,          1'b0, 5'd6, 32'h22,        1'b0, 1'b0, 64'd3};
        vecs[6]  = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'h8012_3456,  1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b1, 64'd4};
        vecs[7]  = '{1'b1, 5'd8, 1'b1, 32'd0,  1'b1, 3'd5, 2'd2, 1'b0, 32'd0,          1'b0, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0, 64'd4};
        vecs[8]  = '{1'b1, 5'd10, 1'b1, 32'h99, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0,         1'b0, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0, 64'd4};
        vecs[9]  = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'hBEEF_1234,  1'b1, 5'd8, 32'h0000_BEEF, 1'b0, 1'b1, 64'd5};
        vecs[10] = '{1'b1, 5'd9, 1'b1, 32'd0,  1'b1, 3'd2, 2'd1, 1'b0, 32'd0,          1'b0, 5'd8, 32'h0000_BEEF, 1'b0, 1'b0, 64'd5};
        vecs[11] = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'hDEAD_BEEF,  1'b0, 5'd8, 32'h0000_BEEF, 1'b1, 1'b1, 64'd6};
        vecs[12] = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'h1234_5678,  1'b0, 5'd8, 32'h0000_BEEF, 1'b0, 1'b1, 64'd6};
        vecs[13] = '{1'b1, 5'd3, 1'b0, 32'h55, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0,          1'b0, 5'd8, 32'h0000_BEEF, 1'b0, 1'b1, 64'd7};
        vecs[14] = '{1'b1, 5'd4, 1'b1, 32'd0,  1'b1, 3'd1, 2'd2, 1'b0, 32'd0,          1'b0, 5'd8, 32'h0000_BEEF, 1'b0, 1'b0, 64'd7};
        vecs[15] = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'h8001_0000,  1'b1, 5'd4, 32'hFFFF_8001, 1'b0, 1'b1, 64'd8};
        vecs[16] = '{1'b1, 5'd2, 1'b1, 32'd0,  1'b1, 3'd4, 2'd1, 1'b0, 32'd0,          1'b0, 5'd4, 32'hFFFF_8001, 1'b0, 1'b0, 64'd8};
        vecs[17] = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'h0000_F000,  1'b1, 5'd2, 32'h0000_00F0, 1'b0, 1'b1, 64'd9};
        vecs[18] = '{1'b1, 5'd1, 1'b1, 32'd0,  1'b1, 3'd3, 2'd0, 1'b0, 32'd0,          1'b0, 5'd2, 32'h0000_00F0, 1'b0, 1'b0, 64'd9};
        vecs[19] = '{1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 3'd0, 2'd0, 1'b1, 32'hFFFF_FFFF,  1'b0, 5'd2, 32'h0000_00F0, 1'b1, 1'b1, 64'd10};

        // Reset state
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0);
        #1;
        chk("reset rf_we",    {63'd0, rf_we},    64'd0);
        chk("reset rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("reset rf_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("reset ld_err",   {63'd0, ld_err},   64'd0);
        chk("reset instret",  instret,           64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].rd_we, vecs[i].result, vecs[i].is_load,
                  vecs[i].f3, vecs[i].lo, vecs[i].rvalid, vecs[i].rdata);
            @(posedge clk); #1;
            chk($sformatf("row%0d rf_we", i),    {63'd0, rf_we},    {63'd0, vecs[i].e_we});
            chk($sformatf("row%0d rf_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].e_waddr});
            chk($sformatf("row%0d rf_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].e_wdata});
            chk($sformatf("row%0d ld_err", i),   {63'd0, ld_err},   {63'd0, vecs[i].e_err});
            chk($sformatf("row%0d in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ready});
            chk($sformatf("row%0d instret", i),  instret,           vecs[i].e_ret);
        end

        // Reset while a load is outstanding, then a late rvalid
        drive(1'b1, 5'd11, 1'b1, 32'd0, 1'b1, 3'd2, 2'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        chk("midload in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0);
        reset = 1'b1;
        #2;
        chk("midload async rf_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("midload async instret",  instret,           64'd0);
        chk("midload async in_ready", {63'd0, in_ready}, 64'd1);
        #2;
        reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("late rvalid rf_we",    {63'd0, rf_we},    64'd0);
        chk("late rvalid rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("late rvalid instret",  instret,           64'd0);
        chk("late rvalid in_ready", {63'd0, in_ready}, 64'd1);
        dmem_rvalid = 1'b0;

        // Random traffic against the behavioural model
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_wait = 1'b0; m_rd = 5'd0; m_we = 1'b0; m_f3 = 3'd0; m_lo = 2'd0;
        x_we = 1'b0; x_waddr = 5'd0; x_wdata = 32'd0; x_err = 1'b0; x_ret = 64'd0;
        for (int c = 0; c < 3000; c++) begin
            logic [32:0] r;
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), 1'($urandom),
                  $urandom, ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3), $urandom);
            if (($urandom_range(0, 3) == 0) && in_ld_funct3 < 3'd3) in_ld_funct3 = in_ld_funct3 + 3'd4;
            chk("rand in_ready", {63'd0, in_ready}, {63'd0, !m_wait});
            x_we  = 1'b0;
            x_err = 1'b0;
            if (!m_wait) begin
                if (in_valid && in_is_load) begin
                    m_wait = 1'b1; m_rd = in_rd; m_we = in_rd_we; m_f3 = in_ld_funct3; m_lo = in_addr_lo;
                end else if (in_valid) begin
                    x_ret = x_ret + 64'd1;
                    if (in_rd_we && in_rd != 5'd0) begin
                        x_we = 1'b1; x_waddr = in_rd; x_wdata = in_result;
                    end
                end
            end else if (dmem_rvalid) begin
                m_wait = 1'b0;
                x_ret  = x_ret + 64'd1;
                r = ref_load(m_f3, m_lo, dmem_rdata);
                if (r[32]) x_err = 1'b1;
                else if (m_we && m_rd != 5'd0) begin
                    x_we = 1'b1; x_waddr = m_rd; x_wdata = r[31:0];
                end
            end
            @(posedge clk); #1;
            chk("rand rf_we",    {63'd0, rf_we},    {63'd0, x_we});
            chk("rand rf_waddr", {59'd0, rf_waddr}, {59'd0, x_waddr});
            chk("rand rf_wdata", {32'd0, rf_wdata}, {32'd0, x_wdata});
            chk("rand ld_err",   {63'd0, ld_err},   {63'd0, x_err});
            chk("rand instret",  instret,           x_ret);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
